// File: rtl/lcd_panel_receiver.sv
// Panel-side responder for the lcd_controller bus: one byte per enable falling edge,
// decoded into a COLSxROWS character RAM with readback, cursor and error status.
module lcd_panel_receiver #(
  parameter int          COLS      = 16,
  parameter int          ROWS      = 2,
  parameter int          DEPTH     = COLS*ROWS,
  parameter int          ADDR_W    = $clog2(DEPTH),
  parameter logic [7:0]  FILL_CHAR = 8'h20
) (
  input  logic              fpga_clk_i,
  input  logic              fpga_reset_i,
  input  logic [7:0]        lcd_data_i,
  input  logic              lcd_enable_i,
  input  logic              lcd_reset_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [7:0]        rd_data_o,
  output logic [ADDR_W-1:0] cursor_o,
  output logic              busy_o,
  output logic              byte_valid_o,
  output logic [7:0]        byte_o,
  output logic [7:0]        err_count_o
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_addr;
  logic              en_q;
  logic [7:0]        data_q;
  logic              lrst_q;
  logic [7:0]        mem [DEPTH];

  logic              fall, printable, seek_ok, err_hit, we;
  logic [ADDR_W-1:0] waddr;
  logic [7:0]        wdata;

  assign busy_o = (state == CLEAR);

  // lrst_q suppresses a capture on the first cycle after lcd_reset_i releases
  always_comb begin
    fall      = en_q & ~lcd_enable_i & lrst_q & lcd_reset_i;
    printable = (data_q >= 8'h20) && (data_q <= 8'h7E);
    seek_ok   = data_q[7] && (int'(data_q[6:0]) < DEPTH);
    err_hit   = fall && ((state == CLEAR) ||
                !((data_q == 8'h01) || (data_q == 8'h02) || printable || seek_ok));
    we        = 1'b0;
    waddr     = cursor_o;
    wdata     = data_q;
    if (fpga_reset_i && lcd_reset_i) begin
      if (state == CLEAR) begin
        we    = 1'b1;
        waddr = clr_addr;
        wdata = FILL_CHAR;
      end else if (fall && printable) begin
        we    = 1'b1;
      end
    end
  end

  always_ff @(posedge fpga_clk_i) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read sees the pre-write contents on a same-cycle collision
  always_ff @(posedge fpga_clk_i) begin
    if (!fpga_reset_i) rd_data_o <= 8'h00;
    else               rd_data_o <= mem[rd_addr_i];
  end

  always_ff @(posedge fpga_clk_i) begin
    if (!fpga_reset_i) begin
      state        <= CLEAR;
      clr_addr     <= '0;
      cursor_o     <= '0;
      byte_valid_o <= 1'b0;
      byte_o       <= 8'h00;
      err_count_o  <= 8'h00;
      en_q         <= 1'b0;
      data_q       <= 8'h00;
      lrst_q       <= 1'b1;
    end else begin
      en_q         <= lcd_enable_i;
      data_q       <= lcd_data_i;
      lrst_q       <= lcd_reset_i;
      byte_valid_o <= fall;
      if (fall) byte_o <= data_q;
      if (err_hit && (err_count_o != 8'hFF)) err_count_o <= err_count_o + 8'd1;

      if (!lcd_reset_i) begin
        state    <= CLEAR;
        clr_addr <= '0;
        cursor_o <= '0;
      end else begin
        case (state)
          CLEAR: begin
            clr_addr <= clr_addr + ADDR_W'(1);
            if (clr_addr == ADDR_W'(DEPTH-1)) begin
              state    <= IDLE;
              clr_addr <= '0;
              cursor_o <= '0;
            end
          end
          IDLE: if (fall) begin
            if (data_q == 8'h01) begin
              state    <= CLEAR;
              clr_addr <= '0;
            end else if (data_q == 8'h02) begin
              cursor_o <= '0;
            end else if (printable) begin
              cursor_o <= (cursor_o == ADDR_W'(DEPTH-1)) ? '0 : cursor_o + ADDR_W'(1);
            end else if (seek_ok) begin
              cursor_o <= ADDR_W'(data_q[6:0]);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lcd_panel_receiver.sv
// Scoreboarded bench for lcd_panel_receiver: captured bytes go through a queue to a monitor,
// RAM/cursor/status are checked with directed expected values.
module tb_lcd_panel_receiver;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              fpga_reset_i, lcd_enable_i, lcd_reset_i;
  logic [7:0]        lcd_data_i;
  logic [ADDR_W-1:0] rd_addr_i;
  logic [7:0]        rd_data_o, byte_o, err_count_o;
  logic [ADDR_W-1:0] cursor_o;
  logic              busy_o, byte_valid_o;

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  lcd_panel_receiver dut (
    .fpga_clk_i(clk), .fpga_reset_i(fpga_reset_i), .lcd_data_i(lcd_data_i),
    .lcd_enable_i(lcd_enable_i), .lcd_reset_i(lcd_reset_i), .rd_addr_i(rd_addr_i),
    .rd_data_o(rd_data_o), .cursor_o(cursor_o), .busy_o(busy_o),
    .byte_valid_o(byte_valid_o), .byte_o(byte_o), .err_count_o(err_count_o)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every byte_valid pulse must match the oldest expected byte
  always @(negedge clk) begin
    if (fpga_reset_i === 1'b1 && byte_valid_o === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_byte_valid", 1, 0);
      else                   chk("byte_o", int'(byte_o), int'(exp_q.pop_front()));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    lcd_data_i   = b;
    lcd_enable_i = 1'b1;
    exp_q.push_back(b);
    tick(1);
    lcd_enable_i = 1'b0;
    tick(1);
  endtask

  task automatic read_chk(input string name, input int addr, input int exp);
    rd_addr_i = ADDR_W'(addr);
    @(posedge clk);
    @(negedge clk);
    chk(name, int'(rd_data_o), exp);
    #1;
  endtask

  task automatic busy_len(input string name, input int exp);
    int cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy_o) cnt++;
      else break;
    end
    chk(name, cnt, exp);
    #1;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy_o && t < 100) begin tick(1); t++; end
    chk("wait_idle_timeout", int'(busy_o), 0);
  endtask

  initial begin
    fpga_reset_i = 1'b0; lcd_reset_i = 1'b1; lcd_enable_i = 1'b0;
    lcd_data_i = 8'h00; rd_addr_i = '0;
    tick(3);
    @(negedge clk);
    chk("rst_busy", int'(busy_o), 1);
    chk("rst_cursor", int'(cursor_o), 0);
    chk("rst_err", int'(err_count_o), 0);
    chk("rst_byte_valid", int'(byte_valid_o), 0);
    chk("rst_byte", int'(byte_o), 0);
    chk("rst_rd_data", int'(rd_data_o), 0);
    @(posedge clk); #1;
    fpga_reset_i = 1'b1;

    // 1: power-on clear
    busy_len("clear_len_por", 32);
    for (int a = 0; a < 32; a++) read_chk("por_fill", a, 8'h20);
    chk("por_cursor", int'(cursor_o), 0);

    // 2: two printable chars
    send(8'h48); send(8'h69); tick(1);
    read_chk("ram0_H", 0, 8'h48);
    read_chk("ram1_i", 1, 8'h69);
    chk("cursor_after_Hi", int'(cursor_o), 2);

    // 3: seek to last cell, wrap, out-of-range seek
    send(8'h9F); tick(1);
    chk("cursor_seek31", int'(cursor_o), 31);
    send(8'h41); tick(1);
    read_chk("ram31_A", 31, 8'h41);
    chk("cursor_wrap", int'(cursor_o), 0);
    send(8'hA0); tick(1);
    chk("err_bad_seek", int'(err_count_o), 1);
    chk("cursor_bad_seek", int'(cursor_o), 0);
    send(8'h02); tick(1);
    chk("cursor_home", int'(cursor_o), 0);

    // 4: clear command, byte dropped while busy
    send(8'h85); send(8'h58); tick(1);
    read_chk("ram5_X", 5, 8'h58);
    chk("cursor_after_X", int'(cursor_o), 6);
    send(8'h01);
    tick(1);
    chk("busy_after_clr_cmd", int'(busy_o), 1);
    send(8'h59); tick(1);
    chk("err_dropped", int'(err_count_o), 2);
    wait_idle();
    read_chk("ram5_cleared", 5, 8'h20);
    read_chk("ram0_cleared", 0, 8'h20);
    chk("cursor_after_clr", int'(cursor_o), 0);

    // 5: lcd_reset_i mid-clear restarts it; strobes during hold and on release are ignored
    send(8'h01);
    tick(10);
    lcd_reset_i = 1'b0;
    lcd_data_i = 8'h41; lcd_enable_i = 1'b1; tick(1);
    lcd_enable_i = 1'b0; tick(1);
    lcd_enable_i = 1'b1; tick(1);
    chk("lrst_busy", int'(busy_o), 1);
    chk("lrst_cursor", int'(cursor_o), 0);
    lcd_reset_i = 1'b1;
    lcd_enable_i = 1'b0;
    busy_len("clear_len_lrst", 32);
    chk("lrst_err_kept", int'(err_count_o), 2);

    // 6: illegal bytes saturate the error counter
    for (int i = 0; i < 300; i++) send(8'h00);
    tick(1);
    chk("err_saturated", int'(err_count_o), 8'hFF);
    chk("cursor_after_junk", int'(cursor_o), 0);
    read_chk("ram0_unchanged", 0, 8'h20);
    read_chk("ram31_unchanged", 31, 8'h20);

    tick(4);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
